// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: captures source edges into sticky pending bits,
// qualifies them against mie / mstatus.MIE, and sequences one trap at a time
// through a REQ -> HANDLER -> IDLE handshake with the CSR/fetch logic.

// Per-source edge detector and sticky pending bit.
module irq_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic src,    // raw source level
  input  logic clr,    // software clear strobe
  input  logic take,   // trap for this source acknowledged
  output logic pend
);
  logic prev_q, prev_d;
  logic pend_q, pend_d;

  // A rising edge sets; clear/take drop the bit, but a same-cycle edge wins.
  always_comb begin
    prev_d = src;
    pend_d = (src & ~prev_q) | (pend_q & ~(clr | take));
  end

  // Edge history and pending state.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
endmodule

module irq_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int NSRC      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC-1:0]      irq_src,
  input  logic [NSRC-1:0]      sw_clr,
  input  logic [BUS_WIDTH-1:0] csr_mie,
  input  logic                 csr_mstatus_mie,
  input  logic                 trap_ack,
  input  logic                 is_mret,
  output logic [BUS_WIDTH-1:0] mip,
  output logic                 trap_req,
  output logic [BUS_WIDTH-1:0] trap_cause,
  output logic                 in_handler
);
  localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HANDLER} state_t;

  // Source index -> mip bit position, which is also the mcause code.
  function automatic logic [4:0] src_code(input logic [GW-1:0] idx);
    case (idx)
      GW'(0):  src_code = 5'd3;   // MSI
      GW'(1):  src_code = 5'd7;   // MTI
      GW'(2):  src_code = 5'd11;  // MEI
      default: src_code = 5'd16;  // UART
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [BUS_WIDTH-1:0] cause_q, cause_d;

  logic [NSRC-1:0]   pend, elig, take;
  logic              win_vld;
  logic [GW-1:0]     win_idx;
  logic              unused_mie;

  assign unused_mie = ^csr_mie;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    irq_pend_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .src  (irq_src[i]),
      .clr  (sw_clr[i]),
      .take (take[i]),
      .pend (pend[i])
    );
    assign elig[i] = pend[i] & csr_mie[src_code(GW'(i))] & csr_mstatus_mie;
  end

  // Fixed priority: MEI > MSI > MTI > UART.
  always_comb begin
    win_vld = |elig;
    win_idx = GW'(3);
    if      (elig[2]) win_idx = GW'(2);
    else if (elig[0]) win_idx = GW'(0);
    else if (elig[1]) win_idx = GW'(1);
  end

  // Trap sequencer: grant and cause freeze in REQ; ack beats a same-cycle withdrawal.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cause_d = cause_q;
    take    = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_REQ;
          grant_d = win_idx;
          cause_d = {1'b1, {(BUS_WIDTH-6){1'b0}}, src_code(win_idx)};
        end
      end
      S_REQ: begin
        if (trap_ack) begin
          take[grant_q] = 1'b1;
          state_d       = S_HANDLER;
        end else if (!elig[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      S_HANDLER: begin
        if (is_mret) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cause_q <= cause_d;
    end
  end

  // Spread the pending bits into their architectural mip positions.
  always_comb begin
    mip = '0;
    for (int i = 0; i < NSRC; i++) mip[src_code(GW'(i))] = pend[i];
  end

  assign trap_req   = (state_q == S_REQ);
  assign in_handler = (state_q == S_HANDLER);
  assign trap_cause = cause_q;
endmodule

// File: tb/tb_irq_arbiter.sv
// Randomized + directed bench for irq_arbiter with a per-cycle scoreboard.
module tb_irq_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_src, sw_clr;
  logic [31:0] csr_mie;
  logic        csr_mstatus_mie, trap_ack, is_mret;
  logic [31:0] mip, trap_cause;
  logic        trap_req, in_handler;

  always #5 clk = ~clk;

  irq_arbiter #(.BUS_WIDTH(32), .NSRC(4)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .sw_clr(sw_clr),
    .csr_mie(csr_mie), .csr_mstatus_mie(csr_mstatus_mie),
    .trap_ack(trap_ack), .is_mret(is_mret), .mip(mip),
    .trap_req(trap_req), .trap_cause(trap_cause), .in_handler(in_handler)
  );

  typedef struct {
    logic [31:0] mip;
    logic        req;
    logic [31:0] cause;
    logic        hdl;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  bit [3:0]    m_pend, m_prev;
  bit          m_req, m_hdl;
  int          m_g;
  logic [31:0] m_cause;

  logic [31:0] g_mie;
  logic        g_gm;

  function automatic int pos(input int i);
    case (i)
      0: return 3;
      1: return 7;
      2: return 11;
      default: return 16;
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  // Advance the spec-level model by one clock using the inputs just driven.
  task automatic model_step(input bit r, input bit [3:0] s, input bit [3:0] c,
                            input logic [31:0] mie, input bit gm, input bit ack, input bit mret);
    bit [3:0] kill;
    bit [3:0] elig;
    int order[4] = '{2, 0, 1, 3};
    exp_t e;
    if (r) begin
      m_pend = 0; m_prev = 0; m_req = 0; m_hdl = 0; m_g = 0; m_cause = 0;
    end else begin
      for (int i = 0; i < 4; i++) elig[i] = m_pend[i] && mie[pos(i)] && gm;
      kill = c;
      if (m_req) begin
        if (ack) begin
          kill[m_g] = 1'b1;
          m_req = 0;
          m_hdl = 1;
        end else if (!elig[m_g]) begin
          m_req = 0;
        end
      end else if (m_hdl) begin
        if (mret) m_hdl = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!m_req && elig[order[k]]) begin
            m_req   = 1;
            m_g     = order[k];
            m_cause = 32'h8000_0000 + 32'(pos(order[k]));
          end
        end
      end
      m_pend = (s & ~m_prev) | (m_pend & ~kill);
      m_prev = s;
    end
    e.mip = 0;
    for (int i = 0; i < 4; i++) e.mip[pos(i)] = m_pend[i];
    e.req = m_req; e.cause = m_cause; e.hdl = m_hdl;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit [3:0] s, input bit [3:0] c, input bit ack, input bit mret);
    @(negedge clk);
    rst = r; irq_src = s; sw_clr = c; csr_mie = g_mie; csr_mstatus_mie = g_gm;
    trap_ack = ack; is_mret = mret;
    model_step(r, s, c, g_mie, g_gm, ack, mret);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Monitor: pop one expected record per clock and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mip", mip, e.mip);
        chk("trap_req", {31'b0, trap_req}, {31'b0, e.req});
        chk("in_handler", {31'b0, in_handler}, {31'b0, e.hdl});
        if (e.req) chk("trap_cause", trap_cause, e.cause);
      end
    end
  end

  initial begin
    logic [31:0] rv;
    rst = 1; irq_src = 0; sw_clr = 0; csr_mie = 0; csr_mstatus_mie = 0;
    trap_ack = 0; is_mret = 0;
    g_mie = 0; g_gm = 0;

    // reset with all sources high
    step(1, 4'hF, 0, 0, 0);
    step(1, 4'hF, 0, 0, 0); settle;
    chk("rst_mip", mip, 32'h0);
    chk("rst_req", {31'b0, trap_req}, 32'h0);
    chk("rst_cause", trap_cause, 32'h0);
    step(0, 4'hF, 0, 0, 0); settle;
    chk("release_mip", mip, 32'h0001_0888);
    step(0, 4'hF, 0, 0, 0); settle;
    chk("release_noreq", {31'b0, trap_req}, 32'h0);
    step(0, 4'hF, 4'hF, 0, 0);
    step(0, 4'h0, 0, 0, 0);

    // single UART trap
    g_mie = 32'h0001_0000; g_gm = 1;
    step(0, 4'h8, 0, 0, 0); settle;
    chk("uart_mip", mip, 32'h0001_0000);
    step(0, 4'h0, 0, 0, 0); settle;
    chk("uart_req", {31'b0, trap_req}, 32'h1);
    chk("uart_cause", trap_cause, 32'h8000_0010);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0); settle;
    chk("uart_hdl", {31'b0, in_handler}, 32'h1);
    chk("uart_ack_mip", mip, 32'h0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1); settle;
    chk("uart_mret", {31'b0, in_handler}, 32'h0);

    // priority MEI over MTI, then MTI
    g_mie = 32'h0001_0888;
    step(0, 4'h6, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0); settle;
    chk("prio_cause", trap_cause, 32'h8000_000B);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1); settle;
    chk("prio_mip_mti", mip, 32'h0000_0080);
    step(0, 0, 0, 0, 0); settle;
    chk("prio_req2", {31'b0, trap_req}, 32'h1);
    chk("prio_cause2", trap_cause, 32'h8000_0007);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // no preemption in REQ, no nesting in HANDLER
    step(0, 4'h8, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0);
    step(0, 4'h4, 0, 0, 0); settle;
    chk("nopreempt_cause", trap_cause, 32'h8000_0010);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0); settle;
    chk("nest_hdl_noreq", {31'b0, trap_req}, 32'h0);
    step(0, 0, 0, 0, 1); settle;
    chk("nest_mret_noreq", {31'b0, trap_req}, 32'h0);
    step(0, 0, 0, 0, 0); settle;
    chk("nest_mei_cause", trap_cause, 32'h8000_000B);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // clear/set race
    g_gm = 0;
    step(0, 4'h8, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0);
    step(0, 4'h8, 4'h8, 0, 0); settle;
    chk("race_mip", mip, 32'h0001_0000);
    step(0, 4'h0, 4'hF, 0, 0);

    // withdrawal and re-request
    g_gm = 1; g_mie = 32'h0001_0000;
    step(0, 4'h8, 0, 0, 0);
    step(0, 4'h0, 0, 0, 0); settle;
    chk("wd_req", {31'b0, trap_req}, 32'h1);
    g_gm = 0;
    step(0, 0, 0, 0, 0); settle;
    chk("wd_drop", {31'b0, trap_req}, 32'h0);
    chk("wd_pend", mip, 32'h0001_0000);
    g_gm = 1;
    step(0, 0, 0, 0, 0); settle;
    chk("wd_rereq_cause", trap_cause, 32'h8000_0010);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      bit [3:0] s, c;
      bit ack, mret, r;
      rv = $urandom;
      s = irq_src ^ {rv[3:0] & rv[7:4]};
      c = rv[11:8] & rv[15:12] & rv[19:16];
      r = ($urandom_range(0, 199) == 0);
      ack  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      mret = m_hdl ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) g_mie = rv[20] ? 32'h0001_0888 : $urandom;
      if ($urandom_range(0, 7) == 0)  g_gm  = ($urandom_range(0, 9) != 0);
      step(r, s, c, ack, mret);
    end

    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Machine-mode interrupt arbiter and trap sequencer placed between the interrupt sources (UART, timer, external, software) and the CSR register file. It captures source edges into sticky pending bits, qualifies them against MIE/mstatus.MIE, picks one winner by fixed priority, and runs a request/acknowledge handshake with the CSR/fetch logic. It blocks re-entry until the handler returns with mret. It replaces the single-source UART level path with a multi-source, one-trap-at-a-time scheduler.

## Interface
- BUS_WIDTH, 32, width of mip/mie/cause buses
- NSRC, 4, number of interrupt sources (fixed order: 0=MSI, 1=MTI, 2=MEI, 3=UART)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- irq_src  in  NSRC  raw source levels; a rising edge sets pending
- sw_clr  in  NSRC  one-cycle clear strobes for pending bits (CSR write to mip)
- csr_mie  in  BUS_WIDTH  current mie register
- csr_mstatus_mie  in  1  mstatus.MIE (global enable)
- trap_ack  in  1  CSR/fetch has taken the trap: mepc/mcause latched, redirect issued
- is_mret  in  1  mret retiring this cycle
- mip  out  BUS_WIDTH  pending view: bit3=MSI, bit7=MTI, bit11=MEI, bit16=UART, others 0
- trap_req  out  1  trap request to CSR/fetch
- trap_cause  out  BUS_WIDTH  mcause value for the request, {1'b1, 26'b0, code[4:0]}
- in_handler  out  1  a trap is being serviced; nesting blocked

## Operation
- Edge capture: prev_src register. pend[i] is set when irq_src[i] & ~prev_src[i]. pend[i] is cleared by sw_clr[i], or by trap_ack when i is the granted source. Set wins over clear in the same cycle.
- Qualify: elig[i] = pend[i] & csr_mie[bit(i)] & csr_mstatus_mie; bit(i) = 3, 7, 11, 16.
- Priority, highest first: MEI(11) > MSI(3) > MTI(7) > UART(16).
- FSM states: IDLE, REQ, HANDLER.
  - IDLE: if any elig, latch grant index and cause, go to REQ. Otherwise stay.
  - REQ: trap_req=1. trap_cause and grant stay frozen; later higher-priority arrivals do not preempt. On trap_ack, clear pend[grant] and go to HANDLER. If elig[grant] drops before ack (pending cleared, or mie/mstatus.MIE cleared), withdraw: return to IDLE with trap_req=0 the next cycle.
  - HANDLER: in_handler=1, trap_req=0. Pending bits keep accumulating. On is_mret go to IDLE; arbitration restarts the following cycle.
- is_mret outside HANDLER is ignored. trap_ack outside REQ is ignored and clears nothing.
- Cause code is 5 bits, zero-extended, MSB forced to 1. UART cause = 0x80000010; MEI = 0x8000000B; MSI = 0x80000003; MTI = 0x80000007.

## Timing
- Reset: pend=0, prev_src=0, state=IDLE, trap_req=0, trap_cause=0, in_handler=0, mip=0.
- Edge on irq_src at cycle N: pend and mip visible at N+1. If enabled, state=REQ and trap_req=1 at N+2.
- trap_ack at cycle M (in REQ): at M+1, trap_req=0, in_handler=1, pend[grant]=0.
- is_mret at cycle K (in HANDLER): at K+1, state=IDLE. Earliest next trap_req is K+2.
- trap_req is registered. It is held stable with constant trap_cause until ack or withdrawal.
- A level held high does not re-trigger. A new trap needs a new rising edge.
- rst asserted in any state returns everything to reset values on the next edge. Edges present during reset are lost (prev_src resets to 0, so a level still high at release is captured as an edge the first cycle after reset).

## Test plan
- Reset: assert rst for 2 cycles with irq_src=4'hF. Hold irq_src, release reset -> all pend set at release+1 (mip=0x00010888); no trap_req while mstatus_mie=0.
- Single UART: mie=0x10000, mstatus_mie=1, pulse irq_src[3] at N -> mip=0x10000 at N+1; trap_req=1, cause=0x80000010 at N+2. Ack at N+4 -> mip=0, in_handler=1 at N+5. mret at N+8 -> idle at N+9.
- Priority: edges on MTI and MEI same cycle, all enabled -> cause=0x8000000B. After ack+mret -> second request cause=0x80000007, mip bit7 still set until then.
- No preemption / nesting: UART in REQ, MEI edge arrives -> cause stays 0x80000010 until ack. MEI edge during HANDLER -> no trap_req until the cycle after mret+1.
- Withdrawal: in REQ, clear mstatus_mie -> trap_req=0 next cycle, state IDLE, pend bit retained. Re-enable -> request reasserts with the same cause.
- Clear/set race: sw_clr[3] and a new UART edge in the same cycle -> pend[3]=1.
